cla_4bit: RTL and testbench
===========================

CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 a  input  4  operand A, unsigned or two's complement.
REQ-005 b  input  4  operand B.
REQ-006 cin  input  1  carry in.
REQ-007 sum  output  4  combinational sum bits, for cascading into wider adders.
REQ-008 cout  output  1  combinational carry out (c4).
REQ-009 pg  output  1  combinational group propagate.
REQ-010 gg  output  1  combinational group generate.
REQ-011 sum_q  output  4  registered sum.
REQ-012 cout_q  output  1  registered carry out.
REQ-013 ovf_q  output  1  registered signed overflow.

Function
REQ-014 Per-bit generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i] SHALL be formed for i=0..3, with c0=cin.
REQ-015 Carries SHALL be computed in flattened lookahead form, with no ripple chain:
- c1=g0|p0c0
- c2=g1|p1g0|p1p0c0
- c3=g2|p2g1|p2p1g0|p2p1p0c0
- c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0
REQ-016 sum[i] SHALL equal p[i]^c[i], and cout SHALL equal c4.
REQ-017 pg SHALL equal p3&p2&p1&p0.
REQ-018 gg SHALL equal g3|p3g2|p3p2g1|p3p2p1g0.
REQ-019 cout SHALL always equal gg|(pg&cin).
REQ-020 {cout,sum} SHALL equal a+b+cin as a 5-bit unsigned result for all 512 input combinations.
REQ-021 Combinational outputs SHALL be valid in the same cycle as their inputs and SHALL NOT depend on clk or rst.
REQ-022 On every rising clk edge with rst high, the registers SHALL capture sum_q<=sum, cout_q<=cout and ovf_q<=c4^c3.
REQ-023 Registered latency SHALL be exactly 1 cycle.
REQ-024 There is no handshake; the registers SHALL load every cycle.
REQ-025 Wrap-around: 15+1+0 SHALL produce sum 0 and cout 1.
REQ-026 Maximum case: 15+15+1 SHALL produce sum 15 and cout 1.

Reset
REQ-027 When rst is low, sum_q, cout_q and ovf_q SHALL clear to 0 immediately, independent of clk.
REQ-028 While rst is held low, the registered outputs SHALL remain 0.
REQ-029 Reset SHALL NOT affect sum, cout, pg or gg.
REQ-030 Reset asserted mid-operation SHALL discard any pending result.
REQ-031 The first capture after reset deassertion SHALL occur at the next rising clk edge.

Structure
REQ-032 A shared package cla_pkg SHALL define the constant CLA_W=4 and no other types.
REQ-033 A single sub-module, cla_pg_cell, SHALL compute the per-bit g/p pair and be instantiated four times.
REQ-034 The lookahead equations and output registers SHALL be implemented in cla_4bit itself.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- a=14, b=1, cin=0 -> sum=15, cout=0, pg=1, gg=0; one edge later sum_q=15, cout_q=0.
- a=14, b=1, cin=1 -> sum=0, cout=1, gg=0, pg=1; registered ovf_q=0.
- a=7, b=1, cin=0 -> sum=8, cout=0, ovf_q=1 after one edge.
- a=15, b=15, cin=1 -> sum=15, cout=1, gg=1, pg=0.
- rst driven low between clock edges while a=9, b=9 -> sum_q, cout_q and ovf_q read 0 at once; sum=2 and cout=1 stay live.
- Exhaustive sweep of all 512 combinations -> {cout,sum}==a+b+cin and cout==gg|(pg&cin) for every combination.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants for the 4-bit carry-lookahead adder slice.
package cla_pkg;
    localparam int CLA_W = 4;
endpackage

// File: rtl/cla_4bit_if.sv
// Operand/result bundle for cla_4bit: operands in, combinational and registered results out.
interface cla_4bit_if
    import cla_pkg::*;
();
    logic [CLA_W-1:0] a;
    logic [CLA_W-1:0] b;
    logic             cin;
    logic [CLA_W-1:0] sum;
    logic             cout;
    logic             pg;
    logic             gg;
    logic [CLA_W-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    modport master (
        output a, b, cin,
        input  sum, cout, pg, gg, sum_q, cout_q, ovf_q
    );

    modport slave (
        input  a, b, cin,
        output sum, cout, pg, gg, sum_q, cout_q, ovf_q
    );
endinterface

// File: rtl/cla_pg_cell.sv
// Single-bit generate/propagate cell feeding the lookahead network.
module cla_pg_cell (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);
    assign g = a & b;
    assign p = a ^ b;
endmodule

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with flattened carries, group P/G for cascading,
// and a one-cycle registered sum/carry/overflow stage.
module cla_4bit
    import cla_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    cla_4bit_if.slave  bus
);
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;

    logic [CLA_W-1:0] sum_q_reg;
    logic             cout_q_reg;
    logic             ovf_q_reg;

    generate
        for (genvar gi = 0; gi < CLA_W; gi++) begin : g_pg
            cla_pg_cell u_pg (
                .a (bus.a[gi]),
                .b (bus.b[gi]),
                .g (g[gi]),
                .p (p[gi])
            );
        end
    endgenerate

    // Every carry is a two-level sum of products of g/p and cin; no carry feeds another.
    assign c[0] = bus.cin;
    assign c[1] = g[0] | (p[0] & bus.cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bus.cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bus.cin);

    assign bus.sum  = p ^ c[CLA_W-1:0];
    assign bus.cout = c[4];
    assign bus.pg   = &p;
    assign bus.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);

    // Signed overflow is the carry into the sign bit disagreeing with the carry out of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q_reg  <= '0;
            cout_q_reg <= 1'b0;
            ovf_q_reg  <= 1'b0;
        end else begin
            sum_q_reg  <= bus.sum;
            cout_q_reg <= c[4];
            ovf_q_reg  <= c[4] ^ c[3];
        end
    end

    assign bus.sum_q  = sum_q_reg;
    assign bus.cout_q = cout_q_reg;
    assign bus.ovf_q  = ovf_q_reg;
endmodule

// File: tb/tb_cla_4bit.sv
// Self-checking bench for cla_4bit: combinational outputs checked against an
// arithmetic model, registered outputs checked through a scoreboard queue.
module tb_cla_4bit;
    import cla_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [5:0] sb_q[$];

    cla_4bit_if bus ();

    cla_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one operand set between edges, check the combinational result at once,
    // then check the registered result one edge later via the scoreboard.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] total;
        logic [4:0] total_nc;
        logic       ovf;
        logic       exp_pg;
        logic       exp_gg;
        logic [5:0] exp_reg;
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        #1;
        total    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        total_nc = {1'b0, a} + {1'b0, b};
        ovf      = (a[3] == b[3]) && (total[3] != a[3]);
        exp_pg   = ((a ^ b) == 4'hF);
        exp_gg   = total_nc[4];
        check_val("sum_cout", {27'b0, bus.cout, bus.sum}, {27'b0, total});
        check_val("pg", {31'b0, bus.pg}, {31'b0, exp_pg});
        check_val("gg", {31'b0, bus.gg}, {31'b0, exp_gg});
        check_val("cout_rel", {31'b0, bus.cout}, {31'b0, exp_gg | (exp_pg & cin)});
        sb_q.push_back({ovf, total});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_reg = sb_q.pop_front();
            check_val("reg_out", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, {26'b0, exp_reg});
        end
        $display("[TB] a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d pg=%0d gg=%0d | sum_q=%0d cout_q=%0d ovf_q=%0d",
                 a, b, cin, bus.sum, bus.cout, bus.pg, bus.gg, bus.sum_q, bus.cout_q, bus.ovf_q);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        bus.a   = 4'd3;
        bus.b   = 4'd4;
        bus.cin = 1'b0;
        #1 rst = 1'b0;
        #2;
        check_val("rst_regs", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, 32'd0);
        check_val("rst_comb", {27'b0, bus.cout, bus.sum}, 32'd7);
        @(posedge clk);
        #1;
        check_val("rst_hold", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Directed cases
        apply(4'd14, 4'd1, 1'b0);
        apply(4'd14, 4'd1, 1'b1);
        apply(4'd7,  4'd1, 1'b0);
        apply(4'd15, 4'd1, 1'b0);
        apply(4'd15, 4'd15, 1'b1);
        apply(4'd9,  4'd9, 1'b0);

        // Asynchronous reset between edges with a=9, b=9 still applied
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_regs", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, 32'd0);
        check_val("mid_rst_comb", {27'b0, bus.cout, bus.sum}, 32'd18);
        @(posedge clk);
        #1;
        check_val("mid_rst_hold", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rel_no_cap", {26'b0, bus.ovf_q, bus.cout_q, bus.sum_q}, 32'd0);
        apply(4'd3, 4'd4, 1'b1);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            apply(i[3:0], i[7:4], i[8]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
